// File: rtl/syscall_console.sv
// Reassembles the data memory's toggle-framed syscall character stream into NUL-terminated strings.
// Bytes reach out_valid two cycles after the input is stable; a full FIFO drops bytes and sets overflow.

// Generic first-word-fall-through FIFO; head is visible on pop_dat the cycle after the push.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_vld,
   input  logic [WIDTH-1:0]         push_dat,
   output logic                     push_rdy,
   output logic                     pop_vld,
   output logic [WIDTH-1:0]         pop_dat,
   input  logic                     pop_rdy,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign pop_vld  = (count != '0);
   assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
   assign pop      = pop_vld & pop_rdy;
   assign push_rdy = (count != FULL_CNT) | pop;
   assign push     = push_vld & push_rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push & ~pop)
            count <= count + CNT_ONE;
         else if (pop & ~push)
            count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end
endmodule

// Console stage: event decode, string FSM and length tracking in front of the byte FIFO.
// Two-cycle input-to-output latency; out_ready low holds the head byte and lets the FIFO fill.
module syscall_console #(
   parameter int DEPTH     = 16,
   parameter int LEN_W     = 16,
   parameter int APPEND_NL = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     syscall_w,
   input  logic [31:0]              char_in,
   output logic                     out_valid,
   output logic [7:0]               out_data,
   input  logic                     out_ready,
   output logic                     str_done,
   output logic [LEN_W-1:0]         str_len,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   logic             syscall_s1, syscall_s2;
   logic             tog_s1, tog_s2;
   logic [7:0]       byte_s1;
   logic [0:0]       state, state_nxt;
   logic [LEN_W-1:0] run_len, len_nxt, term_len;
   logic             start, tick, term;
   logic             push_vld, push_rdy;
   logic [7:0]       push_dat;
   logic             char_unused;

   assign char_unused = ^char_in[31:9];

   assign start = syscall_s1 & ~syscall_s2;
   assign tick  = tog_s1 ^ tog_s2;
   assign busy  = (state == ACTIVE);

   // A start event takes precedence over a coincident tick and restarts the string.
   always_comb begin
      state_nxt = state;
      len_nxt   = run_len;
      push_vld  = 1'b0;
      push_dat  = byte_s1;
      term      = 1'b0;
      term_len  = run_len;
      if (start || (tick && state == ACTIVE)) begin
         if (byte_s1 == 8'h00) begin
            term      = 1'b1;
            term_len  = start ? '0 : run_len;
            state_nxt = IDLE;
            len_nxt   = '0;
            push_vld  = (APPEND_NL != 0);
            push_dat  = 8'h0A;
         end else begin
            push_vld  = 1'b1;
            state_nxt = ACTIVE;
            if (start)
               len_nxt = LEN_ONE;
            else if (run_len != '1)
               len_nxt = run_len + LEN_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syscall_s1 <= 1'b0;
         syscall_s2 <= 1'b0;
         tog_s1     <= 1'b0;
         tog_s2     <= 1'b0;
         byte_s1    <= 8'h00;
         state      <= IDLE;
         run_len    <= '0;
         str_done   <= 1'b0;
         str_len    <= '0;
         overflow   <= 1'b0;
      end else begin
         syscall_s1 <= syscall_w;
         syscall_s2 <= syscall_s1;
         tog_s1     <= char_in[8];
         tog_s2     <= tog_s1;
         byte_s1    <= char_in[7:0];
         state      <= state_nxt;
         run_len    <= len_nxt;
         str_done   <= term;
         if (term) str_len <= term_len;
         if (push_vld & ~push_rdy) overflow <= 1'b1;
      end
   end

   fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .push_rdy (push_rdy),
      .pop_vld  (out_valid),
      .pop_dat  (out_data),
      .pop_rdy  (out_ready),
      .count    (fifo_count)
   );
endmodule

// File: tb/tb_syscall_console.sv
// Directed bench for syscall_console with default parameters (DEPTH=16, LEN_W=16, APPEND_NL=1).
module tb_syscall_console;
   logic        clk;
   logic        reset;
   logic        syscall_w;
   logic [31:0] char_in;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        str_done;
   logic [15:0] str_len;
   logic        busy;
   logic        overflow;
   logic [4:0]  fifo_count;

   int          checks = 0;
   int          failures = 0;
   logic        tog;
   logic [7:0]  q[$];
   int          done_cnt;
   logic [15:0] last_len;

   syscall_console dut (
      .clk        (clk),
      .reset      (reset),
      .syscall_w  (syscall_w),
      .char_in    (char_in),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .str_done   (str_done),
      .str_len    (str_len),
      .busy       (busy),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor samples mid-low-phase: records each accepted byte and each str_done pulse.
   always begin
      @(negedge clk);
      #2;
      if (!reset) begin
         if (out_valid && out_ready) q.push_back(out_data);
         if (str_done) begin
            done_cnt++;
            last_len = str_len;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] qat(input int i);
      if (i < q.size()) return q[i];
      return 8'bx;
   endfunction

   // Present one character for two cycles, optionally flipping the toggle bit and raising syscall_w.
   task automatic put(input logic sys, input logic [7:0] b, input logic flip);
      if (flip) tog = ~tog;
      syscall_w = sys;
      char_in = {23'd0, tog, b};
      repeat (2) @(negedge clk);
      syscall_w = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_out_valid"},  out_valid, 0);
      chk({pfx, "_out_data"},   out_data, 0);
      chk({pfx, "_str_done"},   str_done, 0);
      chk({pfx, "_str_len"},    str_len, 0);
      chk({pfx, "_busy"},       busy, 0);
      chk({pfx, "_overflow"},   overflow, 0);
      chk({pfx, "_fifo_count"}, fifo_count, 0);
   endtask

   initial begin
      logic [7:0] exp_b [19];
      reset = 1'b1;
      syscall_w = 1'b0;
      char_in = 32'd0;
      out_ready = 1'b1;
      tog = 1'b0;
      done_cnt = 0;
      last_len = 16'hFFFF;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst0");
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Basic string "Hi": toggle phases 0,1,0.
      q.delete(); done_cnt = 0;
      put(1'b1, 8'h48, 1'b0);
      chk("basic_busy_mid", busy, 1);
      put(1'b0, 8'h69, 1'b1);
      put(1'b0, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      chk("basic_qsize", q.size(), 3);
      chk("basic_b0", qat(0), 8'h48);
      chk("basic_b1", qat(1), 8'h69);
      chk("basic_b2", qat(2), 8'h0A);
      chk("basic_done_cnt", done_cnt, 1);
      chk("basic_len", last_len, 2);
      chk("basic_busy_end", busy, 0);
      chk("basic_overflow", overflow, 0);

      // Back-pressure: 20 chars into a 16-entry FIFO.
      out_ready = 1'b0; q.delete(); done_cnt = 0;
      put(1'b1, 8'h61, 1'b1);
      for (int i = 1; i < 20; i++) put(1'b0, 8'h61 + 8'(i), 1'b1);
      put(1'b0, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      chk("bp_count", fifo_count, 16);
      chk("bp_overflow", overflow, 1);
      chk("bp_len", last_len, 20);
      chk("bp_done_cnt", done_cnt, 1);
      chk("bp_head_held", out_data, 8'h61);
      chk("bp_qsize_stalled", q.size(), 0);
      out_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("bp_drain_qsize", q.size(), 16);
      for (int i = 0; i < 16; i++) chk($sformatf("bp_drain_%0d", i), qat(i), 8'h61 + 8'(i));
      chk("bp_drain_count", fifo_count, 0);

      // Second string starting in the same toggle phase as the previous NUL.
      q.delete(); done_cnt = 0;
      put(1'b1, 8'h58, 1'b0);
      put(1'b0, 8'h59, 1'b1);
      put(1'b0, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      chk("phase_qsize", q.size(), 3);
      chk("phase_b0", qat(0), 8'h58);
      chk("phase_b1", qat(1), 8'h59);
      chk("phase_len", last_len, 2);
      chk("phase_done_cnt", done_cnt, 1);

      // Abort after 3 chars, then "A" and NUL.
      q.delete(); done_cnt = 0;
      put(1'b1, 8'h31, 1'b1);
      put(1'b0, 8'h32, 1'b1);
      put(1'b0, 8'h33, 1'b1);
      put(1'b1, 8'h41, 1'b1);
      chk("abort_no_done", done_cnt, 0);
      put(1'b0, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      chk("abort_done_cnt", done_cnt, 1);
      chk("abort_len", last_len, 1);
      chk("abort_qsize", q.size(), 5);
      chk("abort_b2", qat(2), 8'h33);
      chk("abort_b3", qat(3), 8'h41);
      chk("abort_b4", qat(4), 8'h0A);

      // Empty string: first byte is NUL.
      q.delete(); done_cnt = 0;
      put(1'b1, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      chk("empty_done_cnt", done_cnt, 1);
      chk("empty_len", last_len, 0);
      chk("empty_qsize", q.size(), 1);
      chk("empty_b0", qat(0), 8'h0A);
      chk("empty_busy", busy, 0);

      // Stray toggles with no syscall are ignored.
      q.delete(); done_cnt = 0;
      for (int i = 0; i < 3; i++) put(1'b0, 8'h5A, 1'b1);
      repeat (3) @(negedge clk);
      chk("stray_count", fifo_count, 0);
      chk("stray_busy", busy, 0);
      chk("stray_done_cnt", done_cnt, 0);

      // Fill to full across the pointer wrap, then push and pop in the same cycle.
      out_ready = 1'b0; q.delete(); done_cnt = 0;
      put(1'b1, 8'h41, 1'b1);
      for (int i = 1; i < 16; i++) put(1'b0, 8'h41 + 8'(i), 1'b1);
      chk("wrap_full", fifo_count, 16);
      chk("wrap_head", out_data, 8'h41);
      for (int k = 0; k < 2; k++) begin
         tog = ~tog;
         char_in = {23'd0, tog, 8'h51 + 8'(k)};
         @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("wrap_hold_count_%0d", k), fifo_count, 16);
         chk($sformatf("wrap_hold_head_%0d", k), out_data, 8'h42 + 8'(k));
      end
      out_ready = 1'b1;
      put(1'b0, 8'h00, 1'b1);
      repeat (25) @(negedge clk);
      for (int i = 0; i < 16; i++) exp_b[i] = 8'h41 + 8'(i);
      exp_b[16] = 8'h51;
      exp_b[17] = 8'h52;
      exp_b[18] = 8'h0A;
      chk("wrap_qsize", q.size(), 19);
      for (int i = 0; i < 19; i++) chk($sformatf("wrap_b%0d", i), qat(i), exp_b[i]);
      chk("wrap_len", last_len, 18);

      // Reset mid-string with 5 bytes buffered.
      out_ready = 1'b0; q.delete(); done_cnt = 0;
      put(1'b1, 8'h61, 1'b1);
      for (int i = 1; i < 5; i++) put(1'b0, 8'h61 + 8'(i), 1'b1);
      chk("pre_rst_count", fifo_count, 5);
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk_reset_outputs("rst_mid");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      put(1'b0, 8'h78, 1'b1);
      put(1'b0, 8'h79, 1'b1);
      repeat (3) @(negedge clk);
      chk("post_rst_count", fifo_count, 0);
      chk("post_rst_busy", busy, 0);
      out_ready = 1'b1; q.delete(); done_cnt = 0;
      put(1'b1, 8'h6B, 1'b1);
      put(1'b0, 8'h00, 1'b1);
      repeat (5) @(negedge clk);
      chk("post_rst_qsize", q.size(), 2);
      chk("post_rst_b0", qat(0), 8'h6B);
      chk("post_rst_b1", qat(1), 8'h0A);
      chk("post_rst_len", last_len, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/syscall_console.md
# syscall_console

Console output stage downstream of the data memory's syscall string port. Watches the 9-bit character stream that the data memory drives after a print-string syscall: bits [7:0] are the byte, bit [8] toggles once per new character. Reassembles each NUL-terminated string into a byte FIFO. Drains the FIFO over a valid/ready byte interface to the testbench console or a UART, and reports string length and completion.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- LEN_W, 16: width of `str_len`.
- APPEND_NL, 1: when 1, push 8'h0A into the FIFO at each string terminator.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- syscall_w  input  1  syscall strobe, same signal that feeds the data memory's `SyscallW`.
- char_in  input  32  data memory `char` output. [7:0] is the byte, [8] is the toggle bit, [31:9] are ignored.
- out_valid  output  1  FIFO non-empty.
- out_data  output  8  FIFO head byte. Reads 8'h00 when the FIFO is empty.
- out_ready  input  1  consumer accepts `out_data` this cycle.
- str_done  output  1  one-cycle pulse when a terminator is received.
- str_len  output  LEN_W  non-NUL byte count of the last completed string. Held until the next `str_done`.
- busy  output  1  state is ACTIVE.
- overflow  output  1  sticky flag: at least one byte was dropped because the FIFO was full.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Input sampling.** `syscall_w`, `char_in[8]` and `char_in[7:0]` are registered into stage s1, then s1 is registered into s2.
- **Events.** Two event types are decoded from s1 and s2:
  - start = `syscall_s1 & ~syscall_s2`
  - tick = `tog_s1 != tog_s2`
  - The event byte is `byte_s1`.
  - If start and tick coincide, they count as one event, treated as a start.
- **States.**
  - IDLE: a start event moves to ACTIVE, clears the running length, then processes the byte as below. A tick event is ignored.
  - ACTIVE, tick event with byte ≠ 0: push the byte and increment the running length. The length saturates at 2^LEN_W−1.
  - ACTIVE, tick event with byte = 0: terminator. Pulse `str_done`, copy the running length to `str_len`, push 8'h0A if APPEND_NL is 1, return to IDLE.
  - Start event while ACTIVE: abort the current string. No `str_done`, `str_len` is unchanged, the running length is cleared, and the byte is processed as the first character. Bytes already pushed stay in the FIFO.
  - A start event whose byte is 0 (empty string): terminator handling in the same cycle. `str_done` pulses with `str_len` = 0, state stays IDLE.
- **FIFO.** First-word-fall-through, DEPTH entries, wrapping read and write pointers.
  - A pop happens when `out_valid & out_ready`.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `overflow` is set, and the running length still increments.
  - A push and pop in the same cycle leave `fifo_count` unchanged.
  - `out_data` and `out_valid` must not change while `out_valid & ~out_ready`.
- **Reset.** Asynchronous, takes effect in any state including mid-string.
  - Outputs after reset: `out_valid`=0, `out_data`=0, `str_done`=0, `str_len`=0, `busy`=0, `overflow`=0, `fifo_count`=0.
  - s1 and s2 are cleared, pointers go to 0, state goes to IDLE.
  - After reset deasserts, the first tick seen is ignored until a start event occurs.

## Timing
- **Input hold.** Each new `char_in` value, with its toggled bit [8], must stay stable for at least 2 clk periods. Faster toggles may be missed and produce undefined output.
- **Event latency.** If an input is stable before rising edge k:
  - s1 captures it at edge k.
  - The event is decoded between edge k and edge k+1.
  - The FIFO write, length update and state change happen at edge k+1.
  - `out_valid` rises after edge k+1, which is 2-cycle latency.
  - `str_done` is high for the cycle after edge k+1, with `str_len` valid in that same cycle.
- **Throughput.** One push and one pop per cycle maximum.
- **Pop timing.** With `out_ready` held high, each byte is presented for exactly one cycle.
- **Overflow latency.** `overflow` sets at the edge of the dropped push.

## Test plan
- **Basic string.** Syscall rising with "Hi" then NUL, toggle bit alternating 0,1,0, `out_ready`=1. Required: bytes 0x48, 0x69, 0x0A on `out_data`. `str_done` pulses once, `str_len`=2, `busy` is 0 at the end.
- **Back-pressure and overflow.** `out_ready`=0, DEPTH=16, 20-char string with APPEND_NL=1. Required: `fifo_count`=16, `overflow`=1, `str_len`=20. After `out_ready`=1, exactly the first 16 chars drain in order.
- **Second string, same toggle phase.** A second syscall whose first char has the same bit [8] as the previous NUL. Required: the first char is still captured via the start event, and the second `str_len` is correct.
- **Abort and empty string.** A syscall rising mid-string after 3 chars, followed by "A" then NUL. Required: no `str_done` for the aborted string, then `str_len`=1. A separate syscall whose first byte is NUL gives an immediate `str_done` with `str_len`=0 and pushes 0x0A.
- **Stray toggles and wrap-around.** Toggles on `char_in[8]` with no syscall are ignored (`fifo_count` stays 0). Push and pop simultaneously at the full level: the count is held and the data order is preserved across pointer wrap.
- **Reset mid-operation.** Assert reset mid-string with 5 bytes buffered. Required: all outputs at their reset values immediately. Subsequent ticks are ignored until the next syscall rising edge.
